fp_exp_align: RTL

//  Front-end operand-alignment stage of the 16-bit DLfloat adder (1s/6e/9m, bias 31).
//  - Computes the exponent difference as ea + ~eb + 1 (two's-complement subtract).
//  - Swaps operands so the larger-exponent operand is "big".
//  - Right-shifts the small mantissa with guard/round/sticky.
//  - Hands both mantissas to the downstream add/normalise stage.
//  2-stage valid/ready pipeline between operand source and mantissa adder.

---
 rtl/fp_dl16_pkg.sv | 27 ++
 rtl/fp_sticky_rshift.sv | 27 ++
 rtl/fp_exp_align.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fp_dl16_pkg.sv
// DLfloat16 (1s/6e/9m, bias 31) field widths, special exponent and field slicers.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package fp_dl16_pkg;

    localparam int WORD_W  = 16;
    localparam int EXP_W   = 6;
    localparam int MANT_W  = 9;
    localparam int ALIGN_W = 13;
    localparam int BIAS    = 31;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 6'h3F;

    // Word layout is {sign, exp[5:0], mant[8:0]}.
    function automatic logic sign_of(input logic [WORD_W-1:0] x);
        return x[WORD_W-1];
    endfunction

    function automatic logic [EXP_W-1:0] exp_of(input logic [WORD_W-1:0] x);
        return x[WORD_W-2:MANT_W];
    endfunction

    function automatic logic [MANT_W-1:0] mant_of(input logic [WORD_W-1:0] x);
        return x[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/fp_sticky_rshift.sv
// Barrel right shift of an aligned mantissa; every bit shifted out is OR-ed into bit 0.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module fp_sticky_rshift
    import fp_dl16_pkg::*;
(
    input  logic [ALIGN_W-1:0] in,
    input  logic [EXP_W-1:0]   amt,
    output logic [ALIGN_W-1:0] out
);

    logic [ALIGN_W-1:0] ones;
    logic [ALIGN_W-1:0] lost_mask;
    logic [ALIGN_W-1:0] shifted;

    // Shift, then fold the bits that fell off the bottom into the sticky position.
    always_comb begin
        ones      = '1;
        lost_mask = ~(ones << amt);
        shifted   = in >> amt;
        out       = shifted | {{(ALIGN_W-1){1'b0}}, |(in & lost_mask)};
        if (amt >= EXP_W'(ALIGN_W)) begin
            out = {{(ALIGN_W-1){1'b0}}, |in};
        end
    end

endmodule

// File: rtl/fp_exp_align.sv
// DLfloat16 adder front end: exponent compare, operand swap, sticky alignment of small mantissa.
// Latency: 2 cycles from input acceptance to out_valid, 1 pair per cycle.
// Backpressure: in_ready drops only when both stages are full and out_ready is low.
module fp_exp_align
    import fp_dl16_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   a_in,
    input  logic [WORD_W-1:0]   b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [EXP_W-1:0]    exp_out,
    output logic [ALIGN_W-1:0]  mant_big,
    output logic [ALIGN_W-1:0]  mant_small,
    output logic                sign_big,
    output logic                eff_sub,
    output logic                swapped,
    output logic                special
);

    // Stage 1 registers
    logic                s1_valid;
    logic [EXP_W-1:0]    s1_exp_big;
    logic [ALIGN_W-1:0]  s1_big_src;
    logic [ALIGN_W-1:0]  s1_small_src;
    logic [EXP_W-1:0]    s1_diff;
    logic                s1_sign_big;
    logic                s1_eff_sub;
    logic                s1_swapped;
    logic                s1_special;

    logic                s1_adv;

    // Stage 1 combinational datapath
    logic [EXP_W-1:0]    ea, eb;
    logic [EXP_W:0]      d7;
    logic                swap;
    logic [EXP_W-1:0]    diff;
    logic [WORD_W-1:0]   big_word, small_word;
    logic [ALIGN_W-1:0]  big_src, small_src;
    logic [ALIGN_W-1:0]  shifted_small;

    assign s1_adv   = !out_valid | out_ready;
    assign in_ready = !s1_valid | s1_adv;

    // Exponent difference via two's-complement add; carry-out clear means ea < eb.
    always_comb begin
        ea         = exp_of(a_in);
        eb         = exp_of(b_in);
        d7         = {1'b0, ea} + {1'b0, ~eb} + 7'd1;
        swap       = ~d7[EXP_W];
        diff       = swap ? (~d7[EXP_W-1:0] + 6'd1) : d7[EXP_W-1:0];
        big_word   = swap ? b_in : a_in;
        small_word = swap ? a_in : b_in;
        // Exponent 0 encodes zero (no subnormals), so the hidden bit is simply exp != 0.
        big_src    = {(exp_of(big_word)   != '0), mant_of(big_word),   3'b000};
        small_src  = {(exp_of(small_word) != '0), mant_of(small_word), 3'b000};
    end

    // Stage 1 register: capture swapped fields and shift amount when the slot is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_exp_big   <= '0;
            s1_big_src   <= '0;
            s1_small_src <= '0;
            s1_diff      <= '0;
            s1_sign_big  <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_swapped   <= 1'b0;
            s1_special   <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_ready && in_valid) begin
                s1_exp_big   <= exp_of(big_word);
                s1_big_src   <= big_src;
                s1_small_src <= small_src;
                s1_diff      <= diff;
                s1_sign_big  <= sign_of(big_word);
                s1_eff_sub   <= sign_of(a_in) ^ sign_of(b_in);
                s1_swapped   <= swap;
                s1_special   <= (ea == EXP_SPECIAL) || (eb == EXP_SPECIAL);
            end
        end
    end

    fp_sticky_rshift u_rshift (
        .in  (s1_small_src),
        .amt (s1_diff),
        .out (shifted_small)
    );

    // Stage 2 register: aligned result; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            exp_out    <= '0;
            mant_big   <= '0;
            mant_small <= '0;
            sign_big   <= 1'b0;
            eff_sub    <= 1'b0;
            swapped    <= 1'b0;
            special    <= 1'b0;
        end else begin
            if (s1_adv) begin
                out_valid <= s1_valid;
            end
            if (s1_adv && s1_valid) begin
                exp_out    <= s1_exp_big;
                mant_big   <= s1_big_src;
                mant_small <= shifted_small;
                sign_big   <= s1_sign_big;
                eff_sub    <= s1_eff_sub;
                swapped    <= s1_swapped;
                special    <= s1_special;
            end
        end
    end

endmodule
